mpu_control_fsm: RTL
====================

Name: mpu_control_fsm

Overview:
- Multi-cycle control unit for the 8-bit accumulator soft MPU.
- Sits directly upstream of the datapath. It consumes the datapath status outputs (instruction register byte, Aeq0, Apos) and produces every datapath load, select and write strobe.
- It sequences fetch, operand fetch, memory access and execute, with a configurable memory read latency.

Parameters:
- MEM_RD_LAT, 1, memory read latency in cycles. Legal values are 1..4. Address must be held stable for MEM_RD_LAT cycles before data is consumed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- InstReg  in  8  current instruction byte from the datapath.
- Aeq0  in  1  accumulator == 0.
- Apos  in  1  accumulator bit 7 == 0.
- IRload  out  1  load instruction register.
- MRload  out  1  load memory address register.
- PCload  out  1  load PC.
- MemInst  out  1  memory address select: 0 = PC, 1 = MAR.
- MemWr  out  1  memory write strobe.
- Aload  out  1  load accumulator.
- RFwr  out  1  register file write.
- outen  out  1  load output register.
- JMPsel  out  2  PC source: 00 = PC+1, 01 = absolute (memory byte), 10 = PC+rel, 11 = PC-rel.
- SHsel  out  2  shifter mode: 00 = pass, 01 = shl, 10 = shr, 11 = rotr.
- Asel  out  2  accumulator source: 00 = shifter, 01 = RF, 10 = Input, 11 = memory byte.
- ALUsel  out  3  ALU op: 000 = passA, 001 = AND, 010 = OR, 011 = NOT, 100 = ADD, 101 = SUB, 110 = INC, 111 = DEC.
- halted  out  1  high while in HALT.
- state  out  3  current state encoding, for debug.

Behaviour:
- Clock and reset: one clock (clk). While rst = 0, the state is forced to FETCH with the wait counter at 0, and all strobes plus halted are 0. Selects default to 0.
- Outputs: combinational from the current state, InstReg, Aeq0 and Apos. Every strobe defaults to 0, and selects default to 0 when unused.
- Decode: opcode = InstReg[7:4]. Rn = InstReg[2:0]. Relative direction = InstReg[3] (0 fwd, 1 back).
- Opcodes:
  - 0 LDR Rn: A <= R[n].
  - 1 STR Rn: R[n] <= A.
  - 2 LD a: A <= M[a].
  - 3 ST a: M[a] <= A.
  - 4 LDI i: A <= i.
  - 5/6/7/8 ADD/SUB/AND/OR Rn.
  - 9 UNARY: InstReg[1:0] selects 00 NOT, 01 INC, 10 DEC, 11 passA.
  - A SHIFT: ALUsel = passA, SHsel = InstReg[1:0].
  - B IO: InstReg[0] = 0 is IN, = 1 is OUT.
  - C HALT.
  - D JMP a.
  - E JZ rel.
  - F JPOS rel.
- Opcodes 2, 3, 4 and D are two-byte instructions; the operand is the next byte.
- FETCH: MemInst = 0; no strobes. Held for MEM_RD_LAT cycles using the wait counter, then goes to LATCH_IR.
- LATCH_IR: IRload = 1, PCload = 1, JMPsel = 00. Next state is EXEC.
- EXEC:
  - LDR: Asel = 01, Aload.
  - STR: RFwr.
  - ALU ops: ALUsel per op, SHsel = 00, Asel = 00, Aload.
  - SHIFT and UNARY: as decoded above, Asel = 00, Aload.
  - IN: Asel = 10, Aload.
  - OUT: outen.
  - JZ/JPOS taken: PCload with JMPsel = 10 + InstReg[3]. Not taken: no strobe.
  - All of the above return to FETCH.
  - HALT goes to HALT.
  - Two-byte instructions go to OPND_WAIT.
- OPND_WAIT: MemInst = 0. Held for MEM_RD_LAT cycles, then goes to OPND_USE.
- OPND_USE:
  - LD/ST: MRload, PCload, JMPsel = 00. Next state is MEM.
  - LDI: Asel = 11, Aload, PCload, JMPsel = 00. Next state is FETCH.
  - JMP: PCload, JMPsel = 01. Next state is FETCH.
- MEM: MemInst = 1.
  - ST: MemWr = 1 on the first cycle only, then FETCH.
  - LD: held for MEM_RD_LAT cycles, then MEM_USE.
- MEM_USE: MemInst = 1, Asel = 11, Aload. Next state is FETCH.
- HALT: all strobes 0, halted = 1. Left only by reset.
- Cycle counts at MEM_RD_LAT = 1:
  - 1-byte instruction: 3.
  - LDI/JMP: 5.
  - ST: 6.
  - LD: 7.
- Each wait state adds MEM_RD_LAT-1 cycles.
- Conditional jumps sample Aeq0/Apos in EXEC. The PC is already incremented there, so the offset is relative to the following instruction.
- Reset asserted mid-instruction: the state returns to FETCH immediately and strobes drop to 0 in the same cycle. No partial MemWr is allowed after reset asserts.
- Reset deassert: the first fetch starts on the next rising edge.
- PC wrap-around at address 63 is a datapath concern; the FSM imposes no restriction.

Test Plan:
- Reset: hold rst = 0 for 3 cycles, release. Expect state = FETCH, all strobes 0 during reset, and IRload = 1 exactly 1 cycle after release (MEM_RD_LAT = 1).
- 1-byte ALU op: InstReg = 8'h53 (ADD R3) in EXEC. Expect ALUsel = 100, Asel = 00, SHsel = 00, Aload = 1 for one cycle, then FETCH; total 3 cycles.
- LD sequence: InstReg = 8'h20, MEM_RD_LAT = 1. Expect MRload in cycle 4, MemInst = 1 in cycles 5-6, Asel = 11 + Aload in cycle 6, FETCH at cycle 7.
- ST: InstReg = 8'h30. Expect MemWr = 1 for exactly one cycle with MemInst = 1, Aload never asserted.
- JZ: InstReg = 8'hE9. With Aeq0 = 1, expect PCload = 1 and JMPsel = 11 in EXEC. With Aeq0 = 0, expect no PCload. Repeat for JPOS 8'hF2 with Apos = 1 → JMPsel = 10.
- HALT and latency:
  - InstReg = 8'hC0 → halted = 1 permanently with no strobes for 20 cycles; rst pulse clears it.
  - With MEM_RD_LAT = 3, a 1-byte op takes 5 cycles.
  - rst asserted during MEM of ST → MemWr = 0 immediately.

Source files
------------

// File: rtl/mpu_control_fsm.sv
// mpu_control_fsm
//   Multi-cycle control unit for the 8-bit accumulator soft MPU. It sequences
//   fetch, operand fetch, memory access and execute. It drives every datapath
//   load, select and write strobe from the current state, the instruction
//   byte and the accumulator flags.
//
// Parameters
//   MEM_RD_LAT : memory read latency in cycles (1..4). The address is held
//                for this many cycles before the read data is used.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   InstReg[7:0]      : instruction byte held in the datapath IR
//   Aeq0, Apos        : accumulator is zero / accumulator bit 7 is clear
//   IRload, MRload, PCload, MemWr, Aload, RFwr, outen : datapath strobes
//   MemInst           : memory address select (0 = PC, 1 = MAR)
//   JMPsel, SHsel, Asel, ALUsel : datapath selects
//   halted            : high while in HALT
//   state[2:0]        : current state encoding, for debug
module mpu_control_fsm #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] InstReg,
  input  logic       Aeq0,
  input  logic       Apos,
  output logic       IRload,
  output logic       MRload,
  output logic       PCload,
  output logic       MemInst,
  output logic       MemWr,
  output logic       Aload,
  output logic       RFwr,
  output logic       outen,
  output logic [1:0] JMPsel,
  output logic [1:0] SHsel,
  output logic [1:0] Asel,
  output logic [2:0] ALUsel,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    LATCH_IR  = 3'd1,
    EXEC      = 3'd2,
    OPND_WAIT = 3'd3,
    OPND_USE  = 3'd4,
    MEM       = 3'd5,
    MEM_USE   = 3'd6,
    HALT      = 3'd7
  } state_t;

  // Wait counter counts 0..MEM_RD_LAT-1 inside each wait state.
  localparam logic [1:0] LAT_M1 = 2'(MEM_RD_LAT - 1);

  state_t     state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [3:0] opcode;
  logic       lat_done;
  logic       unused_rn2;

  assign opcode     = InstReg[7:4];
  assign lat_done   = (wcnt_q == LAT_M1);
  // Register number is decoded by the datapath, not here.
  assign unused_rn2 = InstReg[2];
  assign state      = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    IRload  = 1'b0;
    MRload  = 1'b0;
    PCload  = 1'b0;
    MemInst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    RFwr    = 1'b0;
    outen   = 1'b0;
    JMPsel  = 2'b00;
    SHsel   = 2'b00;
    Asel    = 2'b00;
    ALUsel  = 3'b000;
    halted  = 1'b0;

    case (state_q)
      FETCH: begin
        if (lat_done) state_d = LATCH_IR;
        else          wcnt_d  = wcnt_q + 2'd1;
      end

      LATCH_IR: begin
        IRload  = 1'b1;
        PCload  = 1'b1;
        state_d = EXEC;
      end

      EXEC: begin
        state_d = FETCH;
        case (opcode)
          4'h0: begin Asel = 2'b01; Aload = 1'b1; end
          4'h1: RFwr = 1'b1;
          4'h5: begin ALUsel = 3'b100; Aload = 1'b1; end
          4'h6: begin ALUsel = 3'b101; Aload = 1'b1; end
          4'h7: begin ALUsel = 3'b001; Aload = 1'b1; end
          4'h8: begin ALUsel = 3'b010; Aload = 1'b1; end
          4'h9: begin
            Aload = 1'b1;
            case (InstReg[1:0])
              2'b00:   ALUsel = 3'b011;
              2'b01:   ALUsel = 3'b110;
              2'b10:   ALUsel = 3'b111;
              default: ALUsel = 3'b000;
            endcase
          end
          4'hA: begin SHsel = InstReg[1:0]; Aload = 1'b1; end
          4'hB: begin
            if (InstReg[0]) outen = 1'b1;
            else begin Asel = 2'b10; Aload = 1'b1; end
          end
          4'hC: state_d = HALT;
          4'hE, 4'hF: begin
            // PC already points past this instruction, so the offset is
            // relative to the following one.
            if ((opcode == 4'hE) ? Aeq0 : Apos) begin
              PCload = 1'b1;
              JMPsel = {1'b1, InstReg[3]};
            end
          end
          default: state_d = OPND_WAIT;  // 2, 3, 4, D carry an operand byte
        endcase
      end

      OPND_WAIT: begin
        if (lat_done) state_d = OPND_USE;
        else          wcnt_d  = wcnt_q + 2'd1;
      end

      OPND_USE: begin
        state_d = FETCH;
        case (opcode)
          4'h2, 4'h3: begin MRload = 1'b1; PCload = 1'b1; state_d = MEM; end
          4'h4: begin Asel = 2'b11; Aload = 1'b1; PCload = 1'b1; end
          4'hD: begin PCload = 1'b1; JMPsel = 2'b01; end
          default: ;
        endcase
      end

      MEM: begin
        MemInst = 1'b1;
        if (opcode == 4'h3) begin
          // Store completes in a single cycle, so the write strobe is
          // never repeated.
          MemWr   = 1'b1;
          state_d = FETCH;
        end else if (lat_done) begin
          state_d = MEM_USE;
        end else begin
          wcnt_d  = wcnt_q + 2'd1;
        end
      end

      MEM_USE: begin
        MemInst = 1'b1;
        Asel    = 2'b11;
        Aload   = 1'b1;
        state_d = FETCH;
      end

      HALT: halted = 1'b1;

      default: state_d = FETCH;
    endcase
  end

endmodule
